// File: rtl/bram_fifo_pkg.sv
// Shared constants for the single-BRAM FIFO family.
// Supported geometries all fill exactly one 36 Kbit block RAM.
package bram_fifo_pkg;

  localparam int BRAM_BITS = 36864;

  localparam int DW_1024X36 = 36;
  localparam int AW_1024X36 = 10;
  localparam int DW_2048X18 = 18;
  localparam int AW_2048X18 = 11;
  localparam int DW_4096X9  = 9;
  localparam int AW_4096X9  = 12;

  function automatic int depth(input int addr_width);
    return 1 << addr_width;
  endfunction

endpackage

// File: rtl/af1024x36_1024x36.sv
// Fixed 1024x36 FIFO built on bram_fifo_sync.
// Error-flag behaviour follows BRAM_FIFO_STICKY_ERR_EN.
module af1024x36_1024x36
  import bram_fifo_pkg::*;
(
  input  logic                  clock0,
  input  logic                  Async_Flush,
  input  logic                  PUSH,
  input  logic [DW_1024X36-1:0] DIN,
  input  logic                  POP,
  output logic [DW_1024X36-1:0] DOUT,
  output logic                  Full,
  output logic                  Empty,
  output logic                  Almost_Full,
  output logic                  Almost_Empty,
  output logic                  Full_Watermark,
  output logic                  Empty_Watermark,
  output logic                  Overrun_Error,
  output logic                  Underrun_Error
);

  bram_fifo_sync #(
    .DATA_WIDTH(DW_1024X36),
    .ADDR_WIDTH(AW_1024X36)
  ) u_fifo (
    .clock0          (clock0),
    .Async_Flush     (Async_Flush),
    .PUSH            (PUSH),
    .DIN             (DIN),
    .POP             (POP),
    .DOUT            (DOUT),
    .Full            (Full),
    .Empty           (Empty),
    .Almost_Full     (Almost_Full),
    .Almost_Empty    (Almost_Empty),
    .Full_Watermark  (Full_Watermark),
    .Empty_Watermark (Empty_Watermark),
    .Overrun_Error   (Overrun_Error),
    .Underrun_Error  (Underrun_Error)
  );

endmodule

// File: rtl/af2048x18_2048x18.sv
// Fixed 2048x18 FIFO built on bram_fifo_sync.
// Error-flag behaviour follows BRAM_FIFO_STICKY_ERR_EN.
module af2048x18_2048x18
  import bram_fifo_pkg::*;
(
  input  logic                  clock0,
  input  logic                  Async_Flush,
  input  logic                  PUSH,
  input  logic [DW_2048X18-1:0] DIN,
  input  logic                  POP,
  output logic [DW_2048X18-1:0] DOUT,
  output logic                  Full,
  output logic                  Empty,
  output logic                  Almost_Full,
  output logic                  Almost_Empty,
  output logic                  Full_Watermark,
  output logic                  Empty_Watermark,
  output logic                  Overrun_Error,
  output logic                  Underrun_Error
);

  bram_fifo_sync #(
    .DATA_WIDTH(DW_2048X18),
    .ADDR_WIDTH(AW_2048X18)
  ) u_fifo (
    .clock0          (clock0),
    .Async_Flush     (Async_Flush),
    .PUSH            (PUSH),
    .DIN             (DIN),
    .POP             (POP),
    .DOUT            (DOUT),
    .Full            (Full),
    .Empty           (Empty),
    .Almost_Full     (Almost_Full),
    .Almost_Empty    (Almost_Empty),
    .Full_Watermark  (Full_Watermark),
    .Empty_Watermark (Empty_Watermark),
    .Overrun_Error   (Overrun_Error),
    .Underrun_Error  (Underrun_Error)
  );

endmodule

// File: rtl/af4096x9_4096x9.sv
// Fixed 4096x9 FIFO built on bram_fifo_sync.
// Error-flag behaviour follows BRAM_FIFO_STICKY_ERR_EN.
module af4096x9_4096x9
  import bram_fifo_pkg::*;
(
  input  logic                 clock0,
  input  logic                 Async_Flush,
  input  logic                 PUSH,
  input  logic [DW_4096X9-1:0] DIN,
  input  logic                 POP,
  output logic [DW_4096X9-1:0] DOUT,
  output logic                 Full,
  output logic                 Empty,
  output logic                 Almost_Full,
  output logic                 Almost_Empty,
  output logic                 Full_Watermark,
  output logic                 Empty_Watermark,
  output logic                 Overrun_Error,
  output logic                 Underrun_Error
);

  bram_fifo_sync #(
    .DATA_WIDTH(DW_4096X9),
    .ADDR_WIDTH(AW_4096X9)
  ) u_fifo (
    .clock0          (clock0),
    .Async_Flush     (Async_Flush),
    .PUSH            (PUSH),
    .DIN             (DIN),
    .POP             (POP),
    .DOUT            (DOUT),
    .Full            (Full),
    .Empty           (Empty),
    .Almost_Full     (Almost_Full),
    .Almost_Empty    (Almost_Empty),
    .Full_Watermark  (Full_Watermark),
    .Empty_Watermark (Empty_Watermark),
    .Overrun_Error   (Overrun_Error),
    .Underrun_Error  (Underrun_Error)
  );

endmodule

// File: rtl/bram_fifo_ram.sv
// Simple dual-port RAM: one write port, one registered read port.
// The read register clears on clr; the array itself is never reset.
module bram_fifo_ram
  import bram_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 36,
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  clr,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] wa,
  input  logic [DATA_WIDTH-1:0] wd,
  input  logic                  re,
  input  logic [ADDR_WIDTH-1:0] ra,
  output logic [DATA_WIDTH-1:0] rd
);

  localparam int DEPTH = depth(ADDR_WIDTH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[wa] <= wd;
  end

  // Read-first: a same-address write in this cycle is not seen.
  always_ff @(posedge clk) begin
    if (clr)     rd <= '0;
    else if (re) rd <= mem[ra];
  end

endmodule

// File: rtl/bram_fifo_sync.sv
// Single-clock FIFO on one block RAM with occupancy/watermark/error flags.
// Define BRAM_FIFO_STICKY_ERR_EN to hold error flags until flush.
module bram_fifo_sync
  import bram_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 36,
  parameter int ADDR_WIDTH = 10,
  parameter int FULL_WM    = 2**ADDR_WIDTH - 16,
  parameter int EMPTY_WM   = 16
) (
  input  logic                  clock0,
  input  logic                  Async_Flush,
  input  logic                  PUSH,
  input  logic [DATA_WIDTH-1:0] DIN,
  input  logic                  POP,
  output logic [DATA_WIDTH-1:0] DOUT,
  output logic                  Full,
  output logic                  Empty,
  output logic                  Almost_Full,
  output logic                  Almost_Empty,
  output logic                  Full_Watermark,
  output logic                  Empty_Watermark,
  output logic                  Overrun_Error,
  output logic                  Underrun_Error
);

  localparam int CW = ADDR_WIDTH + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(depth(ADDR_WIDTH));
  localparam logic [CW-1:0] FWM_C   = CW'(FULL_WM);
  localparam logic [CW-1:0] EWM_C   = CW'(EMPTY_WM);
  localparam logic [CW-1:0] C_ONE   = CW'(1);
  localparam logic [ADDR_WIDTH-1:0] P_ONE = ADDR_WIDTH'(1);

  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic [ADDR_WIDTH-1:0] rd_ptr;
  logic [CW-1:0]         count;
  logic                  wr_en;
  logic                  rd_en;
  logic                  ovr_hit;
  logic                  und_hit;

  // Flush wins over any access in the same cycle.
  assign wr_en   = !Async_Flush && PUSH && (!Full || POP);
  assign rd_en   = !Async_Flush && POP && !Empty;
  assign ovr_hit = PUSH && Full && !POP;
  assign und_hit = POP && Empty;

  bram_fifo_ram #(
    .DATA_WIDTH(DATA_WIDTH),
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_ram (
    .clk (clock0),
    .clr (Async_Flush),
    .we  (wr_en),
    .wa  (wr_ptr),
    .wd  (DIN),
    .re  (rd_en),
    .ra  (rd_ptr),
    .rd  (DOUT)
  );

  always_ff @(posedge clock0) begin
    if (Async_Flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + P_ONE;
      if (rd_en) rd_ptr <= rd_ptr + P_ONE;
      unique case ({wr_en, rd_en})
        2'b10:   count <= count + C_ONE;
        2'b01:   count <= count - C_ONE;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clock0) begin
    if (Async_Flush) begin
      Overrun_Error  <= 1'b0;
      Underrun_Error <= 1'b0;
    end else begin
`ifdef BRAM_FIFO_STICKY_ERR_EN
      Overrun_Error  <= Overrun_Error  | ovr_hit;
      Underrun_Error <= Underrun_Error | und_hit;
`else
      Overrun_Error  <= ovr_hit;
      Underrun_Error <= und_hit;
`endif
    end
  end

  assign Full            = (count == DEPTH_C);
  assign Empty           = (count == '0);
  assign Almost_Full     = (count == DEPTH_C - C_ONE);
  assign Almost_Empty    = (count == C_ONE);
  assign Full_Watermark  = (count >= FWM_C);
  assign Empty_Watermark = (count <= EWM_C);

endmodule

// File: tb/tb_bram_fifo_sync.sv
// Scoreboard bench for bram_fifo_sync (1024x36 default geometry).
// Expected error flags follow BRAM_FIFO_STICKY_ERR_EN when defined.
module tb_bram_fifo_sync;
  import bram_fifo_pkg::*;

  localparam int DW    = 36;
  localparam int AW    = 10;
  localparam int DEPTH = depth(AW);
  localparam int FWM   = DEPTH - 16;
  localparam int EWM   = 16;

  logic          clk = 1'b0;
  logic          flush = 1'b0;
  logic          push = 1'b0;
  logic          pop = 1'b0;
  logic [DW-1:0] din = '0;
  logic [DW-1:0] dout;
  logic full, empty, a_full, a_empty;
  logic f_wm, e_wm, ovr, und;

  always #5 clk = ~clk;

  bram_fifo_sync #(
    .DATA_WIDTH(DW),
    .ADDR_WIDTH(AW)
  ) dut (
    .clock0          (clk),
    .Async_Flush     (flush),
    .PUSH            (push),
    .DIN             (din),
    .POP             (pop),
    .DOUT            (dout),
    .Full            (full),
    .Empty           (empty),
    .Almost_Full     (a_full),
    .Almost_Empty    (a_empty),
    .Full_Watermark  (f_wm),
    .Empty_Watermark (e_wm),
    .Overrun_Error   (ovr),
    .Underrun_Error  (und)
  );

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] model_q[$];
  logic [DW-1:0] exp_q[$];
  int            mcount = 0;
  logic          movr = 1'b0;
  logic          mund = 1'b0;
  logic [DW-1:0] mdout = '0;
  logic          pop_expect = 1'b0;
  logic          pend = 1'b0;

  function automatic logic [DW-1:0] pat(input int a);
    logic [63:0] v;
    v = 64'(a) | (64'(a) << 20) | 64'h55000;
    return v[DW-1:0];
  endfunction

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One cycle: drive at negedge, update model, check flags next negedge.
  task automatic step(input logic f, input logic p,
                      input logic [DW-1:0] d, input logic r);
    logic push_ok, pop_ok, o_hit, u_hit;
    logic [7:0] ef;
    flush = f;
    push  = p;
    din   = d;
    pop   = r;
    push_ok = !f && p && (mcount != DEPTH || r);
    pop_ok  = !f && r && (mcount != 0);
    o_hit   = p && (mcount == DEPTH) && !r;
    u_hit   = r && (mcount == 0);
    pop_expect = pop_ok;
    if (pop_ok) begin
      mdout = model_q.pop_front();
      exp_q.push_back(mdout);
    end
    if (push_ok) model_q.push_back(d);
    if (f) begin
      model_q.delete();
      mdout = '0;
    end
    mcount = model_q.size();
`ifdef BRAM_FIFO_STICKY_ERR_EN
    movr = !f && (movr | o_hit);
    mund = !f && (mund | u_hit);
`else
    movr = !f && o_hit;
    mund = !f && u_hit;
`endif
    @(negedge clk);
    ef = {mcount == DEPTH, mcount == 0, mcount == DEPTH - 1,
          mcount == 1, mcount >= FWM, mcount <= EWM, movr, mund};
    chk("flags", {full, empty, a_full, a_empty, f_wm, e_wm, ovr, und}, ef);
  endtask

  always @(posedge clk) pend = pop_expect;

  always @(negedge clk) begin
    if (pend) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL dout_unexpected: got %h expected no read", dout);
      end else begin
        chk("dout", dout, exp_q.pop_front());
      end
    end
  end

  initial begin
    @(negedge clk);
    step(1'b1, 1'b0, '0, 1'b0);
    step(1'b1, 1'b1, pat(7), 1'b1);
    step(1'b0, 1'b0, '0, 1'b0);
    chk("dout_reset", dout, 0);

    for (int a = 0; a < DEPTH; a++) step(1'b0, 1'b1, pat(a), 1'b0);

    step(1'b0, 1'b1, 36'h0_ABCD_1234, 1'b0);
    step(1'b0, 1'b0, '0, 1'b0);

    step(1'b0, 1'b0, '0, 1'b1);
    step(1'b0, 1'b1, pat(DEPTH), 1'b0);
    step(1'b0, 1'b1, pat(DEPTH + 1), 1'b1);

    for (int a = 0; a < DEPTH; a++) step(1'b0, 1'b0, '0, 1'b1);

    step(1'b0, 1'b0, '0, 1'b0);
    step(1'b0, 1'b0, '0, 1'b1);
    chk("dout_hold", dout, mdout);
    step(1'b0, 1'b0, '0, 1'b0);

    step(1'b0, 1'b1, pat(5), 1'b1);
    step(1'b0, 1'b0, '0, 1'b1);
    step(1'b0, 1'b0, '0, 1'b0);

    step(1'b1, 1'b0, '0, 1'b0);
    step(1'b0, 1'b0, '0, 1'b0);
    chk("dout_flush", dout, 0);
    step(1'b0, 1'b0, '0, 1'b0);
    chk("scoreboard_drain", 64'(exp_q.size()), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
